// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// The enable/flush decode is combinational (Mealy). The memory-wait FSM,
// the wait counter, the stall counter and mem_timeout are clocked.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             err_clear,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_stall;
  logic              load_use;

  // Hazard detection terms; a load to r0 never creates a dependency.
  assign mem_stall = mem_access & ~mem_ready & (state != FAULT);
  assign load_use  = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  // Prioritized enable/flush decode: freeze > branch > load-use > jump.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!reset || (state == FAULT) || mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Memory-wait sequencing with timeout into FAULT.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEMWAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = FAULT;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      FAULT: begin
        if (err_clear) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // FSM state, wait counter and registered fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mem_timeout <= (state_next == FAULT);
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pc_en && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: decode table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  // Decode patterns {pc_en,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,memwb_bubble}
  localparam logic [6:0] D_IDLE   = 7'b1101010;
  localparam logic [6:0] D_FREEZE = 7'b0000001;
  localparam logic [6:0] D_BRANCH = 7'b1111110;
  localparam logic [6:0] D_LOADU  = 7'b0001110;
  localparam logic [6:0] D_JUMP   = 7'b1111010;

  logic             clk;
  logic             reset;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             mem_access;
  logic             mem_ready;
  logic             err_clear;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: is the pipeline faulted, how many frozen cycles the
  // current memory access has spent, and total cycles the PC sat still.
  bit m_fault;
  int m_waited;
  int m_stalls;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .mem_access(mem_access), .mem_ready(mem_ready), .err_clear(err_clear),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_decode();
    bit freeze;
    bit lu;
    freeze = !reset || m_fault || (mem_access && !mem_ready);
    lu = idex_memread && (idex_rt != 0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    if (freeze)          return D_FREEZE;
    if (ex_branch_taken) return D_BRANCH;
    if (lu)              return D_LOADU;
    if (id_jump)         return D_JUMP;
    return D_IDLE;
  endfunction

  function automatic logic [6:0] dut_decode();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};
  endfunction

  task automatic model_clear();
    m_fault  = 1'b0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  // Advance the model by one rising edge, using the pre-edge inputs.
  task automatic model_update();
    logic [6:0] d;
    d = exp_decode();
    if (!reset) begin
      model_clear();
    end else begin
      if (!d[6]) m_stalls++;
      if (m_fault) begin
        if (err_clear) begin
          m_fault  = 1'b0;
          m_waited = 0;
        end
      end else if (m_waited == 0) begin
        if (mem_access && !mem_ready) m_waited = 1;
      end else if (mem_ready) begin
        m_waited = 0;
      end else if (m_waited + 1 >= MEM_TIMEOUT) begin
        m_fault = 1'b1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name);
    logic [11:0] got;
    logic [11:0] exp;
    int sat;
    sat = (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls;
    got = {dut_decode(), mem_timeout, stall_count};
    exp = {exp_decode(), m_fault, CNT_W'(sat)};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mrd, input logic [4:0] irt, input logic br,
                        input logic jmp, input logic macc, input logic mrdy,
                        input logic clr);
    ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
    idex_memread = mrd; idex_rt = irt;
    ex_branch_taken = br; id_jump = jmp;
    mem_access = macc; mem_ready = mrdy; err_clear = clr;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    idle_in();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mrd;
    logic [4:0] irt;
    logic       br;
    logic       jmp;
    logic       macc;
    logic       mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //              rs     rt     urt   mrd   irt    br    jmp   macc  mrdy  expected
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, D_IDLE};
    tbl[1]  = '{5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, D_LOADU};
    tbl[2]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, D_LOADU};
    tbl[3]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, D_IDLE};
    tbl[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, D_IDLE};
    tbl[5]  = '{5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, D_IDLE};
    tbl[6]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, D_BRANCH};
    tbl[7]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, D_BRANCH};
    tbl[8]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, D_JUMP};
    tbl[9]  = '{5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, D_LOADU};
    tbl[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, D_BRANCH};
    tbl[11] = '{5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, D_LOADU};
    tbl[12] = '{5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, D_FREEZE};

    reset = 1'b0;
    idle_in();
    model_clear();
    #1;
    check_val("reset_decode", int'(dut_decode()), int'(D_FREEZE));
    check_val("reset_stall_count", int'(stall_count), 0);
    check_val("reset_mem_timeout", int'(mem_timeout), 0);
    @(negedge clk);
    reset = 1'b1;

    // Decode table, applied from RUN.
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].mrd, tbl[i].irt,
             tbl[i].br, tbl[i].jmp, tbl[i].macc, tbl[i].mrdy, 1'b0);
      #1;
      check_val($sformatf("table[%0d]", i), int'(dut_decode()), int'(tbl[i].exp));
      check_out($sformatf("table_model[%0d]", i));
      tick();
    end

    // Load-use: one bubble cycle, stall_count 0 -> 1.
    apply_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("loaduse_decode", int'(dut_decode()), int'(D_LOADU));
    check_val("loaduse_count_before", int'(stall_count), 0);
    tick();
    idle_in();
    #1;
    check_val("loaduse_count_after", int'(stall_count), 1);
    check_val("loaduse_release", int'(dut_decode()), int'(D_IDLE));

    // Branch together with load-use: branch wins, no stall counted.
    apply_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("br_lu_decode", int'(dut_decode()), int'(D_BRANCH));
    tick();
    idle_in();
    #1;
    check_val("br_lu_count", int'(stall_count), 0);

    // Memory wait of 3 cycles, then ready.
    apply_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("memwait_freeze[%0d]", i), int'(dut_decode()), int'(D_FREEZE));
      check_out("memwait_model");
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_val("memwait_ready_decode", int'(dut_decode()), int'(D_IDLE));
    tick();
    idle_in();
    #1;
    check_val("memwait_count", int'(stall_count), 3);
    check_val("memwait_no_fault", int'(mem_timeout), 0);
    check_out("memwait_done_model");

    // Timeout: MEM_TIMEOUT frozen cycles, then FAULT until err_clear.
    apply_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      #1;
      check_val($sformatf("timeout_freeze[%0d]", i), int'(dut_decode()), int'(D_FREEZE));
      check_val($sformatf("timeout_flag_low[%0d]", i), int'(mem_timeout), 0);
      tick();
    end
    idle_in();
    #1;
    check_val("fault_flag", int'(mem_timeout), 1);
    check_val("fault_freeze", int'(dut_decode()), int'(D_FREEZE));
    tick();
    err_clear = 1'b1;
    #1;
    check_val("errclr_still_frozen", int'(dut_decode()), int'(D_FREEZE));
    check_val("errclr_flag", int'(mem_timeout), 1);
    tick();
    err_clear = 1'b0;
    #1;
    check_val("after_clear_flag", int'(mem_timeout), 0);
    check_val("after_clear_decode", int'(dut_decode()), int'(D_IDLE));
    check_val("after_clear_count", int'(stall_count), 6);

    // Saturation: 20 stall cycles on a 4-bit counter.
    apply_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    idle_in();
    #1;
    check_val("saturation", int'(stall_count), CNT_MAX);

    // Asynchronous reset in the middle of MEMWAIT.
    apply_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_val("async_count", int'(stall_count), 0);
    check_val("async_flag", int'(mem_timeout), 0);
    check_val("async_freeze", int'(dut_decode()), int'(D_FREEZE));
    tick();
    #1;
    check_val("async_held_freeze", int'(dut_decode()), int'(D_FREEZE));
    check_out("async_held_model");
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    #1;
    check_val("async_release", int'(dut_decode()), int'(D_IDLE));
    tick();
    #1;
    check_out("async_after_model");

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 15),
             1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 45),
             1'($urandom_range(0, 99) < 15));
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (!reset) model_clear();
      #1;
      check_out($sformatf("random[%0d]", i));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
